collision_detector: RTL and testbench

- Produces the `collision` strobe consumed by the apple unit, plus a game-over indication for the game controller.
- Sits beside the drawers on the raster path. Each pixel cycle it samples the Draw outputs of the snake head, snake body, apple and border objects and accumulates per-frame hit flags.
- At each frame boundary it resolves the previous frame's flags into at most one event: an apple-eaten pulse or a game-over latch.
- A hold-off window stops one apple overlap from being counted twice while the apple placer relocates.

---
 rtl/collision_detector.sv | 122 ++++++++++++
 tb/tb_collision_detector.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/collision_detector.sv
// Collision detector: accumulates per-frame head coincidences with apple, body and
// border, then resolves them at each frame boundary into an apple pulse or game over.
module collision_detector #(
  parameter int unsigned HOLDOFF_FRAMES = 2,
  parameter int unsigned CNT_W          = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       head_draw,
  input  logic       body_draw,
  input  logic       apple_draw,
  input  logic       border_draw,
  input  logic       restart,
  output logic       collision,
  output logic       game_over,
  output logic [1:0] over_cause
);

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    PLAY       = 2'd1,
    HOLDOFF    = 2'd2,
    GAME_OVER  = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE   = 2'b00;
  localparam logic [1:0] CAUSE_BORDER = 2'b01;
  localparam logic [1:0] CAUSE_BODY   = 2'b10;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_hit_apple;
  logic             r_hit_body;
  logic             r_hit_border;
  logic             r_collision;
  logic             w_collision_next;
  logic [1:0]       r_cause;
  logic [1:0]       w_cause_next;

  logic w_hit_apple;
  logic w_hit_body;
  logic w_hit_border;

  assign w_hit_apple  = head_draw & apple_draw;
  assign w_hit_body   = head_draw & body_draw;
  assign w_hit_border = head_draw & border_draw;

  // Resolution looks only at the flags gathered before the startOfFrame cycle.
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_collision_next = 1'b0;
    w_cause_next     = r_cause;
    if (startOfFrame) begin
      unique case (r_state)
        WAIT_FRAME: w_state_next = PLAY;
        PLAY, HOLDOFF: begin
          if (r_hit_border) begin
            w_state_next = GAME_OVER;
            w_cause_next = CAUSE_BORDER;
          end else if (r_hit_body) begin
            w_state_next = GAME_OVER;
            w_cause_next = CAUSE_BODY;
          end else if (r_state == HOLDOFF) begin
            // Counter saturates at zero; leaving HOLDOFF as it gets there.
            if (r_cnt <= CNT_W'(1)) begin
              w_cnt_next   = '0;
              w_state_next = PLAY;
            end else begin
              w_cnt_next = r_cnt - CNT_W'(1);
            end
          end else if (r_hit_apple) begin
            w_collision_next = 1'b1;
            w_cnt_next       = CNT_W'(HOLDOFF_FRAMES);
            w_state_next     = HOLDOFF;
          end
        end
        GAME_OVER: begin
          if (restart) begin
            w_state_next = WAIT_FRAME;
            w_cause_next = CAUSE_NONE;
          end
        end
        default: w_state_next = WAIT_FRAME;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= WAIT_FRAME;
      r_cnt        <= '0;
      r_hit_apple  <= 1'b0;
      r_hit_body   <= 1'b0;
      r_hit_border <= 1'b0;
      r_collision  <= 1'b0;
      r_cause      <= CAUSE_NONE;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_collision <= w_collision_next;
      r_cause     <= w_cause_next;
      if (startOfFrame) begin
        r_hit_apple  <= w_hit_apple;
        r_hit_body   <= w_hit_body;
        r_hit_border <= w_hit_border;
      end else begin
        r_hit_apple  <= r_hit_apple  | w_hit_apple;
        r_hit_body   <= r_hit_body   | w_hit_body;
        r_hit_border <= r_hit_border | w_hit_border;
      end
    end
  end

  assign collision  = r_collision;
  assign game_over  = (r_state == GAME_OVER);
  assign over_cause = r_cause;

endmodule

// File: tb/tb_collision_detector.sv
// Bench for collision_detector: directed scenarios with literal expectations plus
// randomized frames, all outputs compared every cycle against a frame-level model.
module tb_collision_detector;

  localparam int unsigned HF = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sof = 1'b0;
  logic       head = 1'b0, body = 1'b0, apple = 1'b0, border = 1'b0;
  logic       restart = 1'b0;
  logic       collision;
  logic       game_over;
  logic [1:0] over_cause;

  int errors = 0;
  int checks = 0;

  collision_detector #(.HOLDOFF_FRAMES(HF), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .startOfFrame(sof),
    .head_draw(head), .body_draw(body), .apple_draw(apple), .border_draw(border),
    .restart(restart), .collision(collision), .game_over(game_over),
    .over_cause(over_cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Frame-level model: the game is "waiting", "over", or playing with a number of
  // frames still to skip before apples count again.
  bit waiting = 1'b1, over = 1'b0;
  int skip_left = 0;
  bit seen_apple = 0, seen_body = 0, seen_border = 0;
  bit m_col = 0;
  int m_cause = 0;

  always @(posedge clk) begin
    if (reset) begin
      waiting = 1; over = 0; skip_left = 0;
      seen_apple = 0; seen_body = 0; seen_border = 0;
      m_col = 0; m_cause = 0;
    end else begin
      m_col = 0;
      if (sof) begin
        if (over) begin
          if (restart) begin over = 0; waiting = 1; m_cause = 0; end
        end else if (waiting) begin
          waiting = 0;
        end else if (seen_border) begin
          over = 1; m_cause = 1; skip_left = 0;
        end else if (seen_body) begin
          over = 1; m_cause = 2; skip_left = 0;
        end else if (skip_left > 0) begin
          skip_left--;
        end else if (seen_apple) begin
          m_col = 1; skip_left = HF;
        end
        seen_apple = head & apple; seen_body = head & body; seen_border = head & border;
      end else begin
        seen_apple  = seen_apple  | (head & apple);
        seen_body   = seen_body   | (head & body);
        seen_border = seen_border | (head & border);
      end
    end
  end

  bit prev_col = 0;
  always @(negedge clk) begin
    check("model_collision", int'(collision), int'(m_col));
    check("model_game_over", int'(game_over), int'(over));
    check("model_over_cause", int'(over_cause), m_cause);
    if (prev_col && collision) check("collision_double", 1, 0);
    prev_col = collision;
  end

  // Inputs change 1 time unit after a rising edge; outputs are then read back
  // 1 time unit after the edge that sampled them.
  task automatic cyc(input bit s, input bit h, input bit b, input bit a, input bit bo,
                     input bit rs);
    sof = s; head = h; body = b; apple = a; border = bo; restart = rs;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic apple_frame();
    idle(3);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, 0, 0);
    idle(2);
  endtask

  initial begin
    @(posedge clk); #1;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("reset_collision", int'(collision), 0);
    check("reset_game_over", int'(game_over), 0);
    check("reset_cause", int'(over_cause), 0);
    reset = 1'b0;
    idle(7);
    // First boundary only arms the detector.
    cyc(1, 0, 0, 0, 0, 0);
    check("first_sof_collision", int'(collision), 0);
    check("first_sof_game_over", int'(game_over), 0);

    // Apple hit, then two ignored frames, then a counted one.
    apple_frame();
    cyc(1, 0, 0, 0, 0, 0);
    check("apple_pulse", int'(collision), 1);
    idle(1);
    check("apple_pulse_one_cycle", int'(collision), 0);
    apple_frame();
    cyc(1, 0, 0, 0, 0, 0);
    check("holdoff_1", int'(collision), 0);
    apple_frame();
    cyc(1, 0, 0, 0, 0, 0);
    check("holdoff_2", int'(collision), 0);
    apple_frame();
    cyc(1, 0, 0, 0, 0, 0);
    check("apple_pulse_again", int'(collision), 1);

    // Let holdoff expire, then apple and border in the same frame.
    idle(4); cyc(1, 0, 0, 0, 0, 0);
    idle(4); cyc(1, 0, 0, 0, 0, 0);
    apple_frame();
    cyc(0, 1, 0, 0, 1, 0);
    idle(2);
    cyc(1, 0, 0, 0, 0, 0);
    check("border_game_over", int'(game_over), 1);
    check("border_cause", int'(over_cause), 1);
    check("border_no_pulse", int'(collision), 0);

    // Restart only counts on a frame boundary.
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    check("restart_no_sof", int'(game_over), 1);
    cyc(1, 0, 0, 0, 0, 1);
    check("restart_game_over", int'(game_over), 0);
    check("restart_cause", int'(over_cause), 0);
    apple_frame();
    cyc(1, 0, 0, 0, 0, 0);
    check("partial_frame_no_pulse", int'(collision), 0);

    // Body hit while in holdoff.
    apple_frame();
    cyc(1, 0, 0, 0, 0, 0);
    check("pulse_before_body", int'(collision), 1);
    idle(2); cyc(0, 1, 1, 0, 0, 0); idle(2);
    cyc(1, 0, 0, 0, 0, 0);
    check("body_game_over", int'(game_over), 1);
    check("body_cause", int'(over_cause), 2);

    // Reset during a collision pulse.
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0);
    apple_frame();
    cyc(1, 0, 0, 0, 0, 0);
    check("pulse_before_reset", int'(collision), 1);
    reset = 1'b1;
    cyc(0, 1, 0, 1, 0, 0);
    reset = 1'b0;
    check("reset_kills_pulse", int'(collision), 0);
    check("reset_game_over_low", int'(game_over), 0);

    // Randomized frames, including back-to-back boundaries.
    for (int f = 0; f < 400; f++) begin
      int gap;
      gap = $urandom_range(0, 10);
      for (int i = 0; i < gap; i++) begin
        reset = ($urandom_range(0, 599) == 0);
        cyc(0, $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, 1) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 1) == 0);
      end
      reset = 1'b0;
      cyc(1, $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
          $urandom_range(0, 1) == 0, $urandom_range(0, 49) == 0,
          $urandom_range(0, 2) != 0);
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
